// File: rtl/vlc_pkg.sv
// Shared types and helpers for the VLC bit packer: widths, FSM states,
// registered output record and the fill-to-byte-count helper.
package vlc_pkg;
  localparam int CODE_W = 32;
  localparam int LEN_W  = 6;

  typedef enum logic {ACTIVE = 1'b0, FLUSH2 = 1'b1} state_t;

  typedef struct packed {
    logic              valid;
    logic [CODE_W-1:0] word;
    logic [2:0]        bytes;
    logic              last;
  } out_t;

  // ceil(bits/8) for 1..32 payload bits
  function automatic logic [2:0] fill_to_bytes(input logic [6:0] bits);
    return 3'((bits + 7'd7) >> 3);
  endfunction
endpackage

// File: rtl/vlc_code_mask.sv
// Clears the code bits at and above in_len so codes can be OR-ed into the accumulator.
module vlc_code_mask
  import vlc_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  input  logic [LEN_W-1:0]  len,
  output logic [CODE_W-1:0] masked
);
  // shifts of 32 or more leave the mask all ones
  assign masked = code & ~({CODE_W{1'b1}} << len);
endmodule

// File: rtl/vlc_bit_packer.sv
// Packs right-aligned variable-length codes MSB-first into 32-bit big-endian
// words; flush zero-pads to a byte boundary and marks the final word last.
module vlc_bit_packer
  import vlc_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              run,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  input  logic [LEN_W-1:0]  in_len,
  input  logic              flush,
  output logic              out_valid,
  output logic [CODE_W-1:0] out_word,
  output logic [2:0]        out_bytes,
  output logic              out_last,
  output logic [31:0]       bit_count,
  output logic              busy,
  output logic              error
);
  state_t      state_q, state_d;
  logic [63:0] acc_q, acc_d, acc_app;
  logic [5:0]  fill_q, fill_d;
  logic [5:0]  res_q, res_d;
  logic [31:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  out_t        out_q, out_d;

  logic [CODE_W-1:0] masked;
  logic              len_ok, accept;
  logic [6:0]        new_fill, shamt;

  vlc_code_mask u_mask (
    .code   (in_code),
    .len    (in_len),
    .masked (masked)
  );

  assign len_ok   = (in_len <= 6'd32);
  assign accept   = in_valid && len_ok && (state_q == ACTIVE);
  assign new_fill = {1'b0, fill_q} + (accept ? {1'b0, in_len} : 7'd0);
  // acc is MSB-aligned: the new code lands directly below the current fill
  assign shamt    = 7'd64 - new_fill;
  assign acc_app  = accept ? (acc_q | ({32'b0, masked} << shamt)) : acc_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    fill_d  = fill_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    out_d   = '0;
    case (state_q)
      ACTIVE: begin
        if (in_valid && !len_ok) err_d = 1'b1;
        if (accept) cnt_d = cnt_q + {26'b0, in_len};
        if (flush) begin
          fill_d = '0;
          acc_d  = '0;
          if (new_fill != 7'd0) begin
            out_d.valid = 1'b1;
            out_d.word  = acc_app[63:32];
            if (new_fill <= 7'd32) begin
              out_d.bytes = fill_to_bytes(new_fill);
              out_d.last  = 1'b1;
            end else begin
              out_d.bytes = 3'd4;
              acc_d       = {acc_app[31:0], 32'b0};
              res_d       = {1'b0, new_fill[4:0]};
              state_d     = FLUSH2;
            end
          end
        end else if (new_fill >= 7'd32) begin
          out_d.valid = 1'b1;
          out_d.word  = acc_app[63:32];
          out_d.bytes = 3'd4;
          acc_d       = {acc_app[31:0], 32'b0};
          fill_d      = {1'b0, new_fill[4:0]};
        end else begin
          acc_d  = acc_app;
          fill_d = new_fill[5:0];
        end
      end
      FLUSH2: begin
        // residual is drained unconditionally; anything offered now is lost
        if (in_valid || flush) err_d = 1'b1;
        out_d.valid = 1'b1;
        out_d.word  = acc_q[63:32];
        out_d.bytes = fill_to_bytes({1'b0, res_q});
        out_d.last  = 1'b1;
        acc_d       = '0;
        fill_d      = '0;
        res_d       = '0;
        state_d     = ACTIVE;
      end
      default: state_d = ACTIVE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ACTIVE;
      acc_q   <= '0;
      fill_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      out_q   <= '0;
    end else if (!run) begin
      state_q <= ACTIVE;
      acc_q   <= '0;
      fill_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      out_q   <= out_d;
    end
  end

  assign out_valid = out_q.valid;
  assign out_word  = out_q.word;
  assign out_bytes = out_q.bytes;
  assign out_last  = out_q.last;
  assign bit_count = cnt_q;
  assign busy      = (state_q == FLUSH2);
  assign error     = err_q;
endmodule
